// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: round-robin selection, single-beat write/read
// sequencing with a bounded read-return wait.
module mem_arbiter #(
  parameter int W       = 32,
  parameter int AW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          m0_req_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [W-1:0]  m0_wdata_i,
  input  logic [3:0]    m0_mask_i,
  output logic          m0_gnt_o,
  output logic [W-1:0]  m0_rdata_o,
  output logic          m0_rvalid_o,
  input  logic          m1_req_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [W-1:0]  m1_wdata_i,
  input  logic [3:0]    m1_mask_i,
  output logic          m1_gnt_o,
  output logic [W-1:0]  m1_rdata_o,
  output logic          m1_rvalid_o,
  output logic          mem_rd_en_o,
  output logic          mem_wr_en_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [W-1:0]  mem_wr_data_o,
  output logic [3:0]    mem_wr_mask_o,
  input  logic [W-1:0]  mem_rd_data_i,
  input  logic          mem_rd_valid_i,
  output logic          owner_o,
  output logic          busy_o,
  output logic          err_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;
  logic            prio_q, prio_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic            gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic            rv0_q, rv0_d, rv1_q, rv1_d;
  logic            err_q, err_d;
  logic            rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [W-1:0]    wdata_q, wdata_d;
  logic [3:0]      mask_q, mask_d;

  logic            win;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [W-1:0]    sel_wdata;
  logic [3:0]      sel_mask;
  logic            rd_finish;
  logic [W-1:0]    rd_value;

  // prio_q names the requester that wins when both ask at once
  always_comb begin
    win       = (m0_req_i && m1_req_i) ? prio_q : m1_req_i;
    sel_we    = win ? m1_we_i    : m0_we_i;
    sel_addr  = win ? m1_addr_i  : m0_addr_i;
    sel_wdata = win ? m1_wdata_i : m0_wdata_i;
    sel_mask  = win ? m1_mask_i  : m0_mask_i;
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    prio_d    = prio_q;
    cnt_d     = cnt_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    rv0_d     = 1'b0;
    rv1_d     = 1'b0;
    err_d     = 1'b0;
    rd_en_d   = 1'b0;
    wr_en_d   = 1'b0;
    addr_d    = '0;
    wdata_d   = '0;
    mask_d    = '0;
    rd_finish = 1'b0;
    rd_value  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (m0_req_i || m1_req_i) begin
          owner_d = win;
          prio_d  = ~win;
          addr_d  = sel_addr;
          if (sel_we) begin
            state_d = S_WRITE;
            gnt0_d  = ~win;
            gnt1_d  = win;
            // a write to address 0 is dropped: no strobe and no command data
            if (sel_addr == '0) begin
              err_d = 1'b1;
            end else begin
              wr_en_d = 1'b1;
              wdata_d = sel_wdata;
              mask_d  = sel_mask;
            end
          end else begin
            state_d = S_READ;
            rd_en_d = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
      end
      S_READ: begin
        if (mem_rd_valid_i) begin
          rd_finish = 1'b1;
          rd_value  = mem_rd_data_i;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rd_finish = 1'b1;
          err_d     = 1'b1;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          rd_en_d = 1'b1;
          addr_d  = addr_q;
        end
        if (rd_finish) begin
          state_d = S_DONE;
          gnt0_d  = ~owner_q;
          gnt1_d  = owner_q;
          rv0_d   = ~owner_q;
          rv1_d   = owner_q;
          if (owner_q) rdata1_d = rd_value;
          else         rdata0_d = rd_value;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      prio_q   <= 1'b0;
      cnt_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      rv0_q    <= 1'b0;
      rv1_q    <= 1'b0;
      err_q    <= 1'b0;
      rd_en_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mask_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      prio_q   <= prio_d;
      cnt_q    <= cnt_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      rv0_q    <= rv0_d;
      rv1_q    <= rv1_d;
      err_q    <= err_d;
      rd_en_q  <= rd_en_d;
      wr_en_q  <= wr_en_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mask_q   <= mask_d;
    end
  end

  assign m0_gnt_o      = gnt0_q;
  assign m1_gnt_o      = gnt1_q;
  assign m0_rvalid_o   = rv0_q;
  assign m1_rvalid_o   = rv1_q;
  assign m0_rdata_o    = rdata0_q;
  assign m1_rdata_o    = rdata1_q;
  assign mem_rd_en_o   = rd_en_q;
  assign mem_wr_en_o   = wr_en_q;
  assign mem_addr_o    = addr_q;
  assign mem_wr_data_o = wdata_q;
  assign mem_wr_mask_o = mask_q;
  assign owner_o       = owner_q;
  assign busy_o        = (state_q != S_IDLE);
  assign err_o         = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, corner sequences,
// and randomized transactions/arbitration against a transaction-level model.
module tb_mem_arbiter;
  localparam int W = 32;
  localparam int AW = 16;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [W-1:0]  m0_wdata, m1_wdata;
  logic [3:0]    m0_mask, m1_mask;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [W-1:0]  m0_rdata, m1_rdata;
  logic          mem_rd_en, mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wr_data, mem_rd_data;
  logic [3:0]    mem_wr_mask;
  logic          mem_rd_valid;
  logic          owner, busy, err;

  int n_chk = 0;
  int n_fail = 0;

  mem_arbiter #(.W(W), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_mask_i(m0_mask), .m0_gnt_o(m0_gnt), .m0_rdata_o(m0_rdata), .m0_rvalid_o(m0_rvalid),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_mask_i(m1_mask), .m1_gnt_o(m1_gnt), .m1_rdata_o(m1_rdata), .m1_rvalid_o(m1_rvalid),
    .mem_rd_en_o(mem_rd_en), .mem_wr_en_o(mem_wr_en), .mem_addr_o(mem_addr),
    .mem_wr_data_o(mem_wr_data), .mem_wr_mask_o(mem_wr_mask),
    .mem_rd_data_i(mem_rd_data), .mem_rd_valid_i(mem_rd_valid),
    .owner_o(owner), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  typedef struct {
    int            m;
    bit            we;
    logic [AW-1:0] a;
    logic [W-1:0]  d;
    logic [3:0]    mk;
    int            vc;      // READ cycle (1-based) carrying mem_rd_valid; 0 = never
    logic [W-1:0]  md;
    int            exp_k;   // cycles from request edge to gnt
    bit            exp_err;
    logic [W-1:0]  exp_rd;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected outcome derived from the transaction rules alone
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.exp_rd = '0;
    if (v.we) begin
      r.exp_k   = 1;
      r.exp_err = (v.a == '0);
    end else if (v.vc == 0) begin
      r.exp_k   = TIMEOUT + 1;
      r.exp_err = 1'b1;
    end else begin
      r.exp_k   = v.vc + 1;
      r.exp_err = 1'b0;
      r.exp_rd  = v.md;
    end
    return r;
  endfunction

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_mask = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_mask = '0;
    mem_rd_valid = 0; mem_rd_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic run_txn(input vec_t v, input bit noise, output int gk, output bit ge,
                         output logic [W-1:0] grd, output bit grv, output int nwr,
                         output bit wrm, output bit bad);
    int rc;
    logic [W-1:0] oth;
    gk = 0; ge = 0; grd = '0; grv = 0; nwr = 0; wrm = 0; bad = 0; rc = 0;
    @(negedge clk);
    mem_rd_valid = 0; mem_rd_data = '0;
    oth = (v.m == 0) ? m1_rdata : m0_rdata;
    if (v.m == 0) begin
      m0_req = 1; m0_we = v.we; m0_addr = v.a; m0_wdata = v.d; m0_mask = v.mk;
    end else begin
      m1_req = 1; m1_we = v.we; m1_addr = v.a; m1_wdata = v.d; m1_mask = v.mk;
    end
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (err) ge = 1;
      if (mem_rd_en && mem_wr_en) bad = 1;
      if ((v.m == 0) ? (m1_gnt || m1_rvalid) : (m0_gnt || m0_rvalid)) bad = 1;
      if (busy && (owner != v.m[0])) bad = 1;
      if (mem_wr_en) begin
        nwr++;
        wrm = (mem_addr == v.a) && (mem_wr_data == v.d) && (mem_wr_mask == v.mk);
      end
      if (mem_rd_en) begin
        rc++;
        if (mem_addr != v.a || mem_wr_data != '0 || mem_wr_mask != '0) bad = 1;
      end
      if (!mem_rd_en && !mem_wr_en && (mem_addr != '0 || mem_wr_data != '0 || mem_wr_mask != '0))
        bad = 1;
      if ((v.m == 0) ? m0_gnt : m1_gnt) begin
        gk  = k;
        grv = (v.m == 0) ? m0_rvalid : m1_rvalid;
        grd = (v.m == 0) ? m0_rdata : m1_rdata;
      end
      @(negedge clk);
      m0_req = 0; m1_req = 0;
      if (mem_rd_en && rc == v.vc) begin
        mem_rd_valid = 1; mem_rd_data = v.md;
      end else if (noise && !mem_rd_en && $urandom_range(0, 1) == 1) begin
        mem_rd_valid = 1; mem_rd_data = $urandom;
      end else begin
        mem_rd_valid = 0; mem_rd_data = '0;
      end
      if (gk != 0) break;
    end
    if (((v.m == 0) ? m1_rdata : m0_rdata) !== oth) bad = 1;
  endtask

  task automatic check_txn(input vec_t v, input bit noise);
    int gk, nwr;
    bit ge, grv, wrm, bad;
    logic [W-1:0] grd;
    run_txn(v, noise, gk, ge, grd, grv, nwr, wrm, bad);
    chk("latency", gk, v.exp_k);
    chk("err", ge, v.exp_err);
    chk("bus_rules", bad, 0);
    if (v.we) begin
      chk("wr_strobes", nwr, (v.a != '0) ? 1 : 0);
      if (v.a != '0) chk("wr_cmd", wrm, 1);
    end else begin
      chk("rvalid", grv, 1);
      chk("rdata", grd, v.exp_rd);
    end
    @(posedge clk); #1;
    chk("busy_after", busy, 0);
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{0, 1, 16'h0010, 32'hDEADBEEF, 4'b1111, 0, 32'h0,        1,  0, 32'h0};
    tbl[1] = '{1, 0, 16'h0020, 32'h0,        4'b0000, 2, 32'h12345678, 3,  0, 32'h12345678};
    tbl[2] = '{1, 1, 16'h0000, 32'hA5A5A5A5, 4'b0011, 0, 32'h0,        1,  1, 32'h0};
    tbl[3] = '{0, 0, 16'h0100, 32'h0,        4'b0000, 0, 32'h77777777, 16, 1, 32'h0};
    tbl[4] = '{0, 0, 16'h0004, 32'h0,        4'b0000, 1, 32'hCAFEF00D, 2,  0, 32'hCAFEF00D};
    tbl[5] = '{1, 0, 16'hFFFC, 32'h0,        4'b0000, 15, 32'h0BADF00D, 16, 0, 32'h0BADF00D};
    tbl[6] = '{1, 1, 16'hFFFF, 32'h01234567, 4'b0101, 0, 32'h0,        1,  0, 32'h0};
    tbl[7] = '{0, 0, 16'h0008, 32'h0,        4'b0000, 3, 32'h5A5A0001, 4,  0, 32'h5A5A0001};

    rst = 1;
    idle_inputs();
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_strobes", {mem_rd_en, mem_wr_en, err, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, 0);
    chk("rst_cmd", {mem_addr, mem_wr_data, mem_wr_mask}, 0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;

    // Both requesters hold writes continuously from reset: grants must alternate from m0
    begin
      int q[$];
      bit both;
      both = 0;
      @(negedge clk);
      m0_req = 1; m0_we = 1; m0_addr = 16'h0010; m0_wdata = 32'h1; m0_mask = 4'hF;
      m1_req = 1; m1_we = 1; m1_addr = 16'h0020; m1_wdata = 32'h2; m1_mask = 4'hF;
      for (int c = 0; c < 24; c++) begin
        @(posedge clk); #1;
        if (m0_gnt && m1_gnt) both = 1;
        if (m0_gnt) q.push_back(0);
        if (m1_gnt) q.push_back(1);
      end
      chk("rr_both_gnt", both, 0);
      chk("rr_count_ge6", q.size() >= 6, 1);
      for (int i = 0; i < 6 && i < q.size(); i++) chk("rr_order", q[i], i % 2);
    end

    do_reset();
    foreach (tbl[i]) check_txn(tbl[i], 1'b0);

    for (int i = 0; i < 30; i++) begin
      vec_t v;
      v.m  = $urandom_range(0, 1);
      v.we = $urandom_range(0, 1);
      v.a  = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
      v.d  = $urandom;
      v.mk = 4'($urandom);
      v.vc = $urandom_range(0, TIMEOUT);
      v.md = $urandom;
      check_txn(model(v), 1'b1);
    end

    // Random arbitration: model tracks pending requests and who was served last
    do_reset();
    begin
      bit pend[2];
      logic [AW-1:0] pa[2];
      logic [W-1:0] pd[2];
      int last, exp_w;
      pend[0] = 0; pend[1] = 0;
      last = 1;
      for (int r = 0; r < 30; r++) begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
          if (!pend[i] && $urandom_range(0, 1) == 1) begin
            pend[i] = 1; pa[i] = AW'($urandom_range(1, 16'hFFFF)); pd[i] = $urandom;
          end
        end
        if (!pend[0] && !pend[1]) begin
          pend[0] = 1; pa[0] = AW'($urandom_range(1, 16'hFFFF)); pd[0] = $urandom;
        end
        m0_req = pend[0]; m0_we = 1; m0_addr = pa[0]; m0_wdata = pd[0]; m0_mask = 4'hF;
        m1_req = pend[1]; m1_we = 1; m1_addr = pa[1]; m1_wdata = pd[1]; m1_mask = 4'hF;
        exp_w = (pend[0] && pend[1]) ? (1 - last) : (pend[1] ? 1 : 0);
        @(posedge clk); #1;
        chk("arb_gnt", {m1_gnt, m0_gnt}, (exp_w == 1) ? 2'b10 : 2'b01);
        chk("arb_addr", mem_addr, pa[exp_w]);
        chk("arb_data", mem_wr_data, pd[exp_w]);
        @(negedge clk);
        pend[exp_w] = 0;
        last = exp_w;
        m0_req = pend[0]; m1_req = pend[1];
        @(posedge clk);
      end
      @(negedge clk);
      idle_inputs();
    end

    // Asynchronous reset in the middle of a READ abandons it without gnt
    do_reset();
    begin
      bit any_gnt;
      any_gnt = 0;
      @(negedge clk);
      m0_req = 1; m0_we = 0; m0_addr = 16'h0040;
      @(posedge clk); #1;
      chk("rr_read_entry", mem_rd_en, 1);
      @(negedge clk);
      m0_req = 0;
      @(posedge clk);
      @(posedge clk); #3;
      rst = 1;
      #1;
      chk("arst_rd_en", mem_rd_en, 0);
      chk("arst_busy", busy, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 0;
      for (int c = 0; c < 8; c++) begin
        @(posedge clk); #1;
        if (m0_gnt || m1_gnt || m0_rvalid || m1_rvalid || err || busy) any_gnt = 1;
      end
      chk("arst_no_gnt", any_gnt, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: W, 32, data width of all data buses.
REQ-002 Parameter: AW, 16, address width of all address buses.
REQ-003 Parameter: TIMEOUT, 15, maximum READ-state cycles waited for mem_rd_valid.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 mN_req  input  1  requester N (N=0 CPU, N=1 loader/DMA) transaction request; held with command until mN_gnt.
REQ-007 mN_we  input  1  1 = write, 0 = read.
REQ-008 mN_addr  input  AW  byte address.
REQ-009 mN_wdata  input  W  write data.
REQ-010 mN_mask  input  4  byte write mask.
REQ-011 mN_gnt  output  1  one-cycle pulse: transaction of requester N complete.
REQ-012 mN_rdata  output  W  read data, valid while mN_rvalid.
REQ-013 mN_rvalid  output  1  one-cycle pulse with mN_gnt on read completion.
REQ-014 mem_rd_en / mem_wr_en  output  1  memory read / write strobe.
REQ-015 mem_addr  output  AW; mem_wr_data  output  W; mem_wr_mask  output  4  memory command.
REQ-016 mem_rd_data  input  W; mem_rd_valid  input  1  memory read return.
REQ-017 owner  output  1  requester currently served; busy  output  1  state != IDLE.
REQ-018 err  output  1  one-cycle pulse on timeout or dropped zero-address write.

Function
REQ-019 States SHALL be IDLE, WRITE, READ, DONE; encoding free.
REQ-020 IDLE: no request -> stay; otherwise select winner, latch we/addr/wdata/mask into internal registers, owner<=winner, go WRITE (we=1) or READ (we=0).
REQ-021 Arbitration SHALL be round-robin: single requester wins; both requesting -> requester not served last wins; after reset m0 has priority.
REQ-022 WRITE: drive mem_wr_en=1 with latched addr/data/mask for exactly one cycle, pulse gnt of owner same cycle, next IDLE.
REQ-023 Write to latched address 0 SHALL keep mem_wr_en=0, still pulse gnt, and pulse err.
REQ-024 READ: drive mem_rd_en=1 and mem_addr every cycle; on mem_rd_valid=1 register mem_rd_data into owner rdata, go DONE.
REQ-025 READ timeout: after TIMEOUT cycles without mem_rd_valid, rdata<=0, pulse err, go DONE.
REQ-026 DONE: pulse gnt and rvalid of owner for one cycle, all mem strobes 0, next IDLE.
REQ-027 Latency: write = 2 cycles IDLE-to-IDLE; read = 3 cycles minimum (valid in first READ cycle).
REQ-028 mem_rd_en and mem_wr_en SHALL never be 1 simultaneously; non-owner gnt/rvalid SHALL stay 0.
REQ-029 Outside WRITE/READ all mem outputs SHALL be 0 (mem_wr_mask 4'b0000).
REQ-030 Request deasserted before latching is ignored; once latched, transaction completes regardless of req.
REQ-031 mem_rd_valid outside READ SHALL be ignored.
REQ-032 Timeout counter SHALL clear on every READ entry; width ceil(log2(TIMEOUT+1)).

Reset
REQ-033 rst=1 SHALL immediately force state IDLE, owner=0, priority to m0, counter 0, all outputs 0 (rdata 0), independent of clk.
REQ-034 Reset mid-transaction SHALL abandon it without gnt; first post-reset edge behaves as IDLE.

Verification
REQ-035 m0 write addr 0x0010 data 0xDEADBEEF mask 4'b1111 -> cycle 2 mem_wr_en=1 with those values, m0_gnt=1 same cycle, busy back to 0 next cycle.
REQ-036 m1 read 0x0020, memory returns 0x12345678 two cycles into READ -> m1_rvalid=m1_gnt=1 with m1_rdata=0x12345678, m0 outputs stay 0.
REQ-037 m0 and m1 request continuously from reset -> grants alternate m0,m1,m0,m1; no grant twice in a row to one requester.
REQ-038 m0 read, mem_rd_valid never asserted -> after 15 READ cycles err=1, DONE pulses m0_gnt/m0_rvalid with rdata 0.
REQ-039 m1 write to addr 0x0000 -> mem_wr_en stays 0, m1_gnt=1, err=1.
REQ-040 rst asserted during READ between clock edges -> mem_rd_en and busy drop to 0 before next edge; no gnt after rst release.
